// File: rtl/operand_fetch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// operand_fetch_ctrl_pkg : shared matmul_defs (FSM encoding, K derivation)
// Revision: 1.0
// ============================================================================
`ifndef MATMUL_DEFS_SVH
`define MATMUL_DEFS_SVH
// Number of RAM words spanned by one length-N row or column.
`define MATMUL_K(N, C) ((N) / (C))
`endif

package operand_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/operand_fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
// operand_fetch_ctrl_if : request/hold inputs and fetch/qualifier outputs
// Revision: 1.0
// ============================================================================
interface operand_fetch_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             hold;
  logic [WIDTH-1:0] counter_A;
  logic [WIDTH-1:0] counter_B;
  logic             data_valid;
  logic             acc_first;
  logic             acc_last;
  logic [WIDTH-1:0] row_idx;
  logic [WIDTH-1:0] col_idx;
  logic             busy;
  logic             done;

  modport master (
    input  start, hold,
    output counter_A, counter_B, data_valid, acc_first, acc_last,
           row_idx, col_idx, busy, done
  );

  modport slave (
    output start, hold,
    input  counter_A, counter_B, data_valid, acc_first, acc_last,
           row_idx, col_idx, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/operand_fetch_ctrl_wrap_counter.sv
`default_nettype none
// ============================================================================
// wrap_counter : modulo-MODULUS counter with enable, clear and wrap flag
// Revision: 1.0
// ============================================================================
module wrap_counter #(
  parameter int WIDTH   = 16,
  parameter int MODULUS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);
  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    wrap    = en && (count_q == LAST);
    count_d = count_q;
    if (clr || wrap) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
endmodule
`default_nettype wire

// File: rtl/operand_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// operand_fetch_ctrl : A/B RAM address sequencer for a chunked matrix product
// Revision: 1.0
// ============================================================================
module operand_fetch_ctrl
  import operand_fetch_ctrl_pkg::*;
#(
  parameter int WIDTH           = 16,
  parameter int CHUNK_SIZE      = 4,
  parameter int INNER_DIMENSION = 8,
  parameter int ROWS_A          = 6,
  parameter int COLS_B          = 6
) (
  input logic                  clk,
  input logic                  rst,
  operand_fetch_ctrl_if.master bus
);
  localparam int               K     = `MATMUL_K(INNER_DIMENSION, CHUNK_SIZE);
  localparam logic [WIDTH-1:0] K_W   = WIDTH'(K);
  localparam longint           LIMIT = longint'(1) << WIDTH;

  if ((INNER_DIMENSION % CHUNK_SIZE) != 0 || K == 0) begin : g_bad_chunk
    $error("operand_fetch_ctrl: INNER_DIMENSION must be a nonzero multiple of CHUNK_SIZE");
  end
  if (longint'(ROWS_A) * longint'(K) > LIMIT ||
      longint'(COLS_B) * longint'(K) > LIMIT) begin : g_bad_span
    $error("operand_fetch_ctrl: address span exceeds 2**WIDTH");
  end

  fetch_state_t     state_q, state_d;
  logic             issue, clr, k_wrap, j_wrap, i_wrap;
  logic [WIDTH-1:0] k_cnt, j_cnt, i_cnt, k_nxt;
  logic [WIDTH-1:0] base_a_q, base_a_d, base_b_q, base_b_d;
  logic [WIDTH-1:0] counter_a_q, counter_a_d, counter_b_q, counter_b_d;
  logic [WIDTH-1:0] row_idx_q, row_idx_d, col_idx_q, col_idx_d;
  logic             data_valid_q, data_valid_d;
  logic             acc_first_q, acc_first_d, acc_last_q, acc_last_d;

  assign issue = (state_q == ST_FETCH) && !bus.hold;
  assign clr   = (state_q != ST_FETCH);

  wrap_counter #(.WIDTH(WIDTH), .MODULUS(K)) u_k_cnt (
    .clk(clk), .rst(rst), .en(issue), .clr(clr), .count(k_cnt), .wrap(k_wrap)
  );
  wrap_counter #(.WIDTH(WIDTH), .MODULUS(COLS_B)) u_j_cnt (
    .clk(clk), .rst(rst), .en(k_wrap), .clr(clr), .count(j_cnt), .wrap(j_wrap)
  );
  wrap_counter #(.WIDTH(WIDTH), .MODULUS(ROWS_A)) u_i_cnt (
    .clk(clk), .rst(rst), .en(j_wrap), .clr(clr), .count(i_cnt), .wrap(i_wrap)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.start) state_d = ST_FETCH;
      ST_FETCH: if (i_wrap) state_d = ST_DRAIN;
      ST_DRAIN: state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    base_a_d = base_a_q;
    base_b_d = base_b_q;
    if (clr) begin
      base_a_d = '0;
      base_b_d = '0;
    end else if (j_wrap) begin
      base_a_d = base_a_q + K_W;
      base_b_d = '0;
    end else if (k_wrap) begin
      base_b_d = base_b_q + K_W;
    end

    k_nxt = k_cnt;
    if (clr || k_wrap) begin
      k_nxt = '0;
    end else if (issue) begin
      k_nxt = k_cnt + WIDTH'(1);
    end

    // Registered address equals the word the next issuing cycle will read.
    counter_a_d = '0;
    counter_b_d = '0;
    if (state_d == ST_FETCH) begin
      counter_a_d = base_a_d + k_nxt;
      counter_b_d = base_b_d + k_nxt;
    end

    data_valid_d = issue;
    acc_first_d  = issue && (k_cnt == '0);
    acc_last_d   = k_wrap;
    row_idx_d    = issue ? i_cnt : row_idx_q;
    col_idx_d    = issue ? j_cnt : col_idx_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      base_a_q     <= '0;
      base_b_q     <= '0;
      counter_a_q  <= '0;
      counter_b_q  <= '0;
      row_idx_q    <= '0;
      col_idx_q    <= '0;
      data_valid_q <= 1'b0;
      acc_first_q  <= 1'b0;
      acc_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_a_q     <= base_a_d;
      base_b_q     <= base_b_d;
      counter_a_q  <= counter_a_d;
      counter_b_q  <= counter_b_d;
      row_idx_q    <= row_idx_d;
      col_idx_q    <= col_idx_d;
      data_valid_q <= data_valid_d;
      acc_first_q  <= acc_first_d;
      acc_last_q   <= acc_last_d;
    end
  end

  assign bus.counter_A  = counter_a_q;
  assign bus.counter_B  = counter_b_q;
  assign bus.data_valid = data_valid_q;
  assign bus.acc_first  = acc_first_q;
  assign bus.acc_last   = acc_last_q;
  assign bus.row_idx    = row_idx_q;
  assign bus.col_idx    = col_idx_q;
  assign bus.busy       = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
  assign bus.done       = (state_q == ST_DONE);
endmodule
`default_nettype wire
